// File: rtl/apb3_pkg.sv
// Shared constants and FSM state encoding for the APB3 master bridge.
package apb3_pkg;

  localparam int unsigned APB3_NUM_SLOTS = 16;
  localparam int unsigned APB3_SLOT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb3_state_e;

endpackage

// File: rtl/apb3_slot_decode.sv
// Slot number plus enable to one-hot PSELS vector (combinational).
module apb3_slot_decode
  import apb3_pkg::*;
(
  input  logic [APB3_SLOT_W-1:0]    slot,
  input  logic                      en,
  output logic [APB3_NUM_SLOTS-1:0] psels_c
);

  always_comb begin
    psels_c = '0;
    if (en) psels_c[slot] = 1'b1;
  end

endmodule

// File: rtl/apb3_master_bridge.sv
// APB3 initiator: single-beat fabric commands become SETUP/ACCESS transfers
// on a 16-slot APB bus, with wait-state handling and a bounded timeout.
module apb3_master_bridge
  import apb3_pkg::*;
#(
  parameter int unsigned APB_DWIDTH     = 32,
  parameter int unsigned SLOT_SHIFT     = 24,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      PCLK,
  input  logic                      PRESETN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [31:0]               cmd_addr,
  input  logic [APB_DWIDTH-1:0]     cmd_wdata,
  output logic                      rsp_valid,
  output logic [APB_DWIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [31:0]               PADDR,
  output logic [APB3_NUM_SLOTS-1:0] PSELS,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [APB_DWIDTH-1:0]     PWDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [APB_DWIDTH-1:0]     PRDATA
);

  // A zero TIMEOUT_CYCLES still needs a legal 1-bit counter.
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  apb3_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [APB3_SLOT_W-1:0]    slot_q, slot_d;
  logic                      psel_en_d;
  logic [APB3_NUM_SLOTS-1:0] psels_d;
  logic                      cmd_ready_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic                      penable_d, pwrite_d;
  logic [APB_DWIDTH-1:0]     rsp_rdata_d, pwdata_d;
  logic [31:0]               paddr_d;

  apb3_slot_decode u_slot_decode (
    .slot    (slot_d),
    .en      (psel_en_d),
    .psels_c (psels_d)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    slot_d        = slot_q;
    psel_en_d     = 1'b0;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    penable_d     = 1'b0;
    paddr_d       = PADDR;
    pwrite_d      = PWRITE;
    pwdata_d      = PWDATA;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_d     = ST_SETUP;
          cmd_ready_d = 1'b0;
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_wdata;
          slot_d      = cmd_addr[SLOT_SHIFT +: APB3_SLOT_W];
          psel_en_d   = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        psel_en_d = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        psel_en_d = 1'b1;
        penable_d = 1'b1;
        // PREADY wins over an expiring count.
        if (PREADY) begin
          state_d       = ST_RESP;
          psel_en_d     = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (TO_EN && (cnt_q == CNT_W'(TO_LAST))) begin
          state_d       = ST_RESP;
          psel_en_d     = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PADDR       <= '0;
      PSELS       <= '0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      PADDR       <= paddr_d;
      PSELS       <= psels_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PWDATA      <= pwdata_d;
    end
  end

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Scoreboard bench for apb3_master_bridge: a slave model answers transfers,
// a monitor compares every completion against a spec-level reference model.
module tb_apb3_master_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          PCLK = 1'b0;
  logic          PRESETN = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [31:0]   cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [31:0]   PADDR;
  logic [15:0]   PSELS;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;
  logic [DW-1:0] PRDATA = '0;

  typedef struct {
    logic        wr;
    logic [3:0]  slot;
    logic [31:0] addr;
    logic [31:0] wd;
    int          waits;
    logic [31:0] rd;
    logic        se;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
    int          acc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;

  apb3_master_bridge #(
    .APB_DWIDTH(DW), .SLOT_SHIFT(24), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSELS(PSELS), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: completion within the timeout window is normal, otherwise aborted.
  function automatic exp_t model(input plan_t p, input int acc);
    exp_t e;
    if (p.waits < int'(TO)) begin
      e.rdata = p.wr ? 32'h0 : p.rd;
      e.err   = p.se;
      e.tmo   = 1'b0;
      e.lat   = 3 + p.waits;
    end else begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
      e.tmo   = 1'b1;
      e.lat   = 2 + int'(TO);
    end
    e.acc = acc;
    return e;
  endfunction

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int waits, input logic [31:0] rd, input logic se, output int acc);
    plan_t p;
    bit    got = 0;
    p.wr = wr; p.addr = addr; p.slot = addr[27:24]; p.wd = wd;
    p.waits = waits; p.rd = rd; p.se = se;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (cmd_ready) begin got = 1; break; end
    end
    if (!got) begin
      check("accept_timeout", 1'b0, 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    plan_q.push_back(p);
    exp_q.push_back(model(p, acc));
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge PCLK);
      if (exp_q.size() == 0 && plan_q.size() == 0) begin done = 1; break; end
    end
    if (!done) check("drain_timeout", 1'b0, 64'(exp_q.size()), 64'd0);
    @(posedge PCLK); #1;
  endtask

  // Slave model: follows each transfer, answers after the planned wait count.
  plan_t       cur;
  bit          s_active = 0;
  bit          s_stable = 1;
  int          s_k = 0;
  logic [15:0] s_sel;
  always @(negedge PCLK) begin
    if (!PRESETN) begin
      s_active = 0; PREADY = 1'b0; PSLVERR = 1'b0;
    end else if (!s_active && PSELS != 16'h0 && !PENABLE) begin
      PREADY = 1'b0; PSLVERR = $urandom_range(0, 1) == 1;
      if (plan_q.size() == 0) check("unexpected_setup", 1'b0, 64'(PSELS), 64'd0);
      else begin
        cur = plan_q.pop_front();
        s_active = 1; s_k = 0; s_stable = 1;
        s_sel = 16'(1) << cur.slot;
        check("setup_psels", PSELS == s_sel, 64'(PSELS), 64'(s_sel));
        check("setup_addr", PADDR == cur.addr, 64'(PADDR), 64'(cur.addr));
        check("setup_dir_data", PWRITE == cur.wr && PWDATA == cur.wd, {31'h0, PWRITE, PWDATA}, {31'h0, cur.wr, cur.wd});
      end
    end else if (s_active && PENABLE) begin
      if (PSELS != s_sel || PADDR != cur.addr || PWRITE != cur.wr || PWDATA != cur.wd) s_stable = 0;
      PREADY  = (s_k == cur.waits);
      PSLVERR = (s_k == cur.waits) ? cur.se : ($urandom_range(0, 1) == 1);
      PRDATA  = (s_k == cur.waits) ? cur.rd : $urandom;
      s_k++;
    end else if (s_active) begin
      check("penable_cycles", s_k == ((cur.waits < int'(TO)) ? cur.waits + 1 : int'(TO)),
            64'(s_k), 64'((cur.waits < int'(TO)) ? cur.waits + 1 : int'(TO)));
      check("access_stable", s_stable, 64'(s_stable), 64'd1);
      s_active = 0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
    end else begin
      PREADY = 1'b0; PSLVERR = $urandom_range(0, 1) == 1; PRDATA = $urandom;
    end
  end

  // Monitor: every rsp_valid pulse retires one scoreboard entry.
  exp_t m_e;
  always @(negedge PCLK) begin
    if (PRESETN && rsp_valid) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 1'b0, 64'(rsp_rdata), 64'd0);
      else begin
        m_e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata == m_e.rdata, 64'(rsp_rdata), 64'(m_e.rdata));
        check("rsp_err_timeout", {rsp_err, rsp_timeout} == {m_e.err, m_e.tmo},
              64'({rsp_err, rsp_timeout}), 64'({m_e.err, m_e.tmo}));
        check("rsp_latency", (cyc - m_e.acc) == m_e.lat, 64'(cyc - m_e.acc), 64'(m_e.lat));
        check("resp_bus_idle", PSELS == 16'h0 && !PENABLE, 64'({PSELS, PENABLE}), 64'd0);
      end
    end
  end

  int  a1, a2, w;
  bit  seen;
  initial begin
    #1 PRESETN = 1'b0;
    #2;
    check("reset_outputs",
          cmd_ready && !rsp_valid && rsp_rdata == 0 && !rsp_err && !rsp_timeout &&
          PADDR == 0 && PSELS == 0 && !PENABLE && !PWRITE && PWDATA == 0,
          {cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSELS, PENABLE, PWRITE, 42'(PADDR)}, 64'h8000000000000000);
    repeat (3) @(posedge PCLK);
    #1 PRESETN = 1'b1;
    @(posedge PCLK); #1;

    // Zero-wait read from slot 3
    issue(1'b0, 32'h0300_0010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, a1);
    drain();
    // Write to slot 15 with 4 wait states
    issue(1'b1, 32'hFF00_0040, 32'h1234_5678, 4, 32'hCAFE_F00D, 1'b0, a1);
    drain();
    // Slave error on a read from slot 7 after noisy wait states
    issue(1'b0, 32'h0700_0000, 32'h0, 3, 32'h5555_AAAA, 1'b1, a1);
    drain();
    // Hung slot: timeout
    issue(1'b0, 32'h0500_0004, 32'h0, int'(TO) + 5, 32'h1111_2222, 1'b0, a1);
    drain();
    // PREADY on the last counted cycle completes normally
    issue(1'b0, 32'h0A00_0008, 32'h0, int'(TO) - 1, 32'h7777_8888, 1'b1, a1);
    drain();

    // Back-to-back zero-wait commands, cmd_valid held
    issue(1'b1, 32'h0100_0000, 32'hA5A5_0001, 0, 32'h0, 1'b0, a1);
    issue(1'b0, 32'h0200_0000, 32'h0, 0, 32'h0BAD_CAFE, 1'b0, a2);
    check("b2b_accept_gap", (a2 - a1) == 4, 64'(a2 - a1), 64'd4);
    drain();

    // Asynchronous reset in the middle of ACCESS
    issue(1'b0, 32'h0C00_0000, 32'h0, 6, 32'h3333_4444, 1'b0, a1);
    repeat (2) @(posedge PCLK);
    #2 PRESETN = 1'b0;
    #1;
    check("async_reset_bus", PSELS == 16'h0 && !PENABLE && cmd_ready && !rsp_valid,
          64'({PSELS, PENABLE, cmd_ready, rsp_valid}), 64'b10);
    exp_q.delete();
    plan_q.delete();
    repeat (2) @(posedge PCLK);
    #1 PRESETN = 1'b1;
    seen = 0;
    @(negedge PCLK);
    check("ready_after_reset", cmd_ready, 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen = 1;
      @(negedge PCLK);
    end
    check("no_spurious_rsp", !seen, 64'(seen), 64'd0);
    @(posedge PCLK); #1;

    // Randomized traffic, including timeouts and boundary wait counts
    for (int n = 0; n < 40; n++) begin
      w = int'($urandom_range(0, TO + 1));
      issue($urandom_range(0, 1) == 1, {4'h0, 4'($urandom_range(0, 15)), 24'($urandom)},
            $urandom, w, $urandom, $urandom_range(0, 1) == 1, a1);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks, required completion", checks);
    $fatal(1);
  end

endmodule
